// File: rtl/uart_boot_loader.sv
// UART-to-instruction-memory boot programmer: 8N1 receiver, little-endian word packer,
// sequential memory writer and core-reset control with timeout resync and bypass.
module uart_boot_loader #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 12,
  parameter logic [63:0] END_MARKER   = 64'h0000_0000_0000_0FFF,
  parameter int          TIMEOUT_CYC  = 100000
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              boot_en_i,
  input  logic              rx_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [DATA_W-1:0] END_WORD = END_MARKER[DATA_W-1:0];

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LOAD, DONE, ERR, BYPASS} ld_state_t;

  // ---------------- receiver ----------------
  logic             rx_s1, rx_s2;
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             byte_valid, frame_err, tick;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
    end
  end

  // byte_valid is combinational on the stop-bit sample so a word write follows one cycle later
  always_comb begin
    rx_state_n = rx_state;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    tick       = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
    case (rx_state)
      RX_IDLE: begin
        bit_cnt_n = '0;
        if (!rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (bit_cnt == CNT_W'(HALF - 1)) begin
          bit_cnt_n  = '0;
          bit_idx_n  = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (tick) begin
          bit_cnt_n = '0;
          shreg_n   = {rx_s2, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (tick) begin
          bit_cnt_n  = '0;
          rx_state_n = RX_IDLE;
          byte_valid = rx_s2;
          frame_err  = !rx_s2;
        end else begin
          bit_cnt_n = bit_cnt + CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_t         ld_state, ld_state_n;
  logic [ADDR_W-1:0] wr_addr, wr_addr_n;
  logic              full, full_n;
  logic [IDX_W-1:0]  byte_idx, byte_idx_n;
  logic [DATA_W-1:0] word_buf, word_buf_n, asm_word;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic              we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      ld_state <= LOAD;
      wr_addr  <= '0;
      full     <= 1'b0;
      byte_idx <= '0;
      word_buf <= '0;
      tmo_cnt  <= '0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wdata_o  <= '0;
    end else begin
      ld_state <= ld_state_n;
      wr_addr  <= wr_addr_n;
      full     <= full_n;
      byte_idx <= byte_idx_n;
      word_buf <= word_buf_n;
      tmo_cnt  <= tmo_cnt_n;
      we_o     <= we_n;
      addr_o   <= addr_n;
      wdata_o  <= wdata_n;
    end
  end

  always_comb begin
    asm_word = word_buf;
    for (int i = 0; i < NB; i++) begin
      if (byte_idx == IDX_W'(i)) asm_word[8*i +: 8] = shreg;
    end
  end

  always_comb begin
    ld_state_n = ld_state;
    wr_addr_n  = wr_addr;
    full_n     = full;
    byte_idx_n = byte_idx;
    word_buf_n = word_buf;
    tmo_cnt_n  = tmo_cnt;
    we_n       = 1'b0;
    addr_n     = addr_o;
    wdata_n    = wdata_o;
    case (ld_state)
      LOAD: begin
        if (!boot_en_i) begin
          ld_state_n = BYPASS;
          byte_idx_n = '0;
          word_buf_n = '0;
          tmo_cnt_n  = '0;
        end else if (frame_err) begin
          ld_state_n = ERR;
        end else if (byte_valid) begin
          tmo_cnt_n = '0;
          if (byte_idx == IDX_W'(NB - 1)) begin
            byte_idx_n = '0;
            word_buf_n = '0;
            if (asm_word == END_WORD) begin
              ld_state_n = DONE;
            end else if (full) begin
              ld_state_n = ERR;
            end else begin
              we_n    = 1'b1;
              addr_n  = wr_addr;
              wdata_n = asm_word;
              // the address saturates; the full flag marks the last legal slot as used
              if (wr_addr == '1) full_n = 1'b1;
              else               wr_addr_n = wr_addr + ADDR_W'(1);
            end
          end else begin
            word_buf_n = asm_word;
            byte_idx_n = byte_idx + IDX_W'(1);
          end
        end else if (byte_idx != '0) begin
          if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            byte_idx_n = '0;
            word_buf_n = '0;
            tmo_cnt_n  = '0;
          end else begin
            tmo_cnt_n = tmo_cnt + TMO_W'(1);
          end
        end
      end
      BYPASS: begin
        if (boot_en_i) begin
          ld_state_n = LOAD;
          wr_addr_n  = '0;
          full_n     = 1'b0;
          byte_idx_n = '0;
          word_buf_n = '0;
          tmo_cnt_n  = '0;
        end
      end
      default: ld_state_n = ld_state;
    endcase
  end

  assign core_rst_o = (ld_state == LOAD) || (ld_state == ERR);
  assign done_o     = (ld_state == DONE);
  assign err_o      = (ld_state == ERR);

endmodule
